// File: rtl/fpau_ntt_seq.sv
// fpau_ntt_seq: in-place 256-point Dilithium NTT / inverse NTT sequencer.
// Reads coefficient pairs and twiddles and issues one butterfly at a time to the FPAU.
// It then writes both results back to the same addresses.
// Optional macro SEQ_INVNTT_SCALE_EN: inverse runs append a multiply-by-256^-1 pass.
module fpau_ntt_seq #(
    parameter int          FPAU_LAT = 3,
    parameter logic [31:0] N_INV    = 32'd8347681
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        inv,
    output logic        busy,
    output logic        done,
    output logic [7:0]  mem_raddr,
    output logic        mem_ren,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  mem_waddr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [7:0]  zeta_addr,
    input  logic [31:0] zeta_data,
    output logic        fpau_en,
    output logic [3:0]  fpau_op,
    output logic [31:0] fpau_a0,
    output logic [31:0] fpau_a1,
    output logic [31:0] fpau_omega,
    output logic [31:0] fpau_acc,
    input  logic [31:0] fpau_rsum,
    input  logic [31:0] fpau_out2
);

`ifdef SEQ_INVNTT_SCALE_EN
    localparam bit SCALE_EN = 1'b1;
`else
    localparam bit SCALE_EN = 1'b0;
`endif

    localparam logic [3:0] OP_CT = 4'b0000;
    localparam logic [3:0] OP_GS = 4'b0011;
    localparam int         CW    = $clog2(FPAU_LAT + 1) + 1;

    typedef enum logic [3:0] {
        DRAIN, IDLE, RD0, RD1, RD2, ISSUE, WAIT, WR0, WR1, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;          // drain / FPAU latency counter
    logic [7:0]    j_q, len_q, k_q;
    logic          inv_q, scale_q;
    logic [3:0]    op_q;
    logic [31:0]   a0_q, a1_q, om_q, out2_q;

    logic [8:0]    j_inc, blk_next;
    logic          blk_end, layer_end, last_layer, last_bfly, scale_start;

    // Index bookkeeping: j walks the lower half of each block of 2*len.
    // The block ends when j+1 reaches the upper half, and the layer ends when the next block would start at 256.
    always_comb begin
        j_inc       = {1'b0, j_q} + 9'd1;
        blk_next    = j_inc + {1'b0, len_q};
        blk_end     = |(j_inc[7:0] & len_q);
        layer_end   = blk_end && blk_next[8];
        last_layer  = inv_q ? len_q[7] : len_q[0];
        last_bfly   = layer_end && last_layer;
        scale_start = SCALE_EN && inv_q && last_bfly;
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= DRAIN;
        else     state_q <= state_d;
    end

    // Next-state and output decode; every output is zero outside its own state
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_ren   = 1'b0;
        mem_raddr = 8'd0;
        mem_we    = 1'b0;
        mem_waddr = 8'd0;
        mem_wdata = 32'd0;
        zeta_addr = 8'd0;
        fpau_en   = 1'b0;
        case (state_q)
            DRAIN: if (cnt_q == CW'(FPAU_LAT)) state_d = IDLE;
            IDLE:  if (start) state_d = RD0;
            RD0: begin
                busy      = 1'b1;
                mem_ren   = 1'b1;
                mem_raddr = j_q;
                zeta_addr = scale_q ? 8'd0 : k_q;
                state_d   = RD1;
            end
            RD1: begin
                busy      = 1'b1;
                mem_ren   = !scale_q;
                mem_raddr = scale_q ? 8'd0 : j_q + len_q;
                state_d   = scale_q ? ISSUE : RD2;
            end
            RD2: begin
                busy    = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                busy    = 1'b1;
                fpau_en = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt_q == CW'(FPAU_LAT - 1)) state_d = WR0;
            end
            WR0: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = j_q;
                mem_wdata = fpau_rsum;
                if (!scale_q)           state_d = WR1;
                else if (j_q == 8'hff)  state_d = DONE;
                else                    state_d = RD0;
            end
            WR1: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = j_q + len_q;
                mem_wdata = out2_q;
                state_d   = (last_bfly && !scale_start) ? DONE : RD0;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = DRAIN;
        endcase
    end

    // Datapath: run setup, operand capture, latency counting and index advance
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            j_q     <= 8'd0;
            len_q   <= 8'd0;
            k_q     <= 8'd0;
            inv_q   <= 1'b0;
            scale_q <= 1'b0;
            op_q    <= OP_CT;
            a0_q    <= 32'd0;
            a1_q    <= 32'd0;
            om_q    <= 32'd0;
            out2_q  <= 32'd0;
        end else begin
            case (state_q)
                DRAIN: cnt_q <= cnt_q + CW'(1);
                IDLE: if (start) begin
                    inv_q   <= inv;
                    scale_q <= 1'b0;
                    j_q     <= 8'd0;
                    len_q   <= inv ? 8'd1 : 8'd128;
                    k_q     <= inv ? 8'd255 : 8'd1;
                end
                RD1: begin
                    if (scale_q) begin
                        a0_q <= 32'd0;
                        a1_q <= mem_rdata;
                        om_q <= N_INV;
                        op_q <= OP_CT;
                    end else begin
                        a0_q <= mem_rdata;
                        om_q <= inv_q ? (32'd0 - zeta_data) : zeta_data;
                        op_q <= inv_q ? OP_GS : OP_CT;
                    end
                end
                RD2:   a1_q  <= mem_rdata;
                ISSUE: cnt_q <= '0;
                WAIT:  cnt_q <= cnt_q + CW'(1);
                WR0: begin
                    // out2 is written one cycle later, so hold it here
                    out2_q <= fpau_out2;
                    if (scale_q) j_q <= j_q + 8'd1;
                end
                WR1: begin
                    if (scale_start) begin
                        scale_q <= 1'b1;
                        j_q     <= 8'd0;
                    end else if (layer_end) begin
                        j_q   <= 8'd0;
                        len_q <= inv_q ? (len_q << 1) : (len_q >> 1);
                    end else if (blk_end) begin
                        j_q <= blk_next[7:0];
                    end else begin
                        j_q <= j_inc[7:0];
                    end
                    if (blk_end) k_q <= inv_q ? k_q - 8'd1 : k_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign fpau_op    = op_q;
    assign fpau_a0    = a0_q;
    assign fpau_a1    = a1_q;
    assign fpau_omega = om_q;
    assign fpau_acc   = 32'd0;

endmodule

// File: doc/fpau_ntt_seq.md
# fpau_ntt_seq

- Drives the finite field polynomial arithmetic unit (FPAU) through a full 256-point Dilithium NTT or inverse NTT (Q = 8380417).
- Reads coefficient pairs and twiddles from external synchronous memories, issues one butterfly at a time to the FPAU, and writes the results back in place.
- Sits between the core's coefficient RAM / twiddle ROM and the FPAU; acts as the initiator for the FPAU's en/op handshake.

## Interface
Parameters:
- FPAU_LAT, 3: cycles from the FPAU sampling en until rsum/out2 are valid.
- N_INV, 8347681: 256^-1 mod Q, used by the optional scaling pass.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only when idle and drained.
- inv  in  1  0 = forward NTT, 1 = inverse; sampled with start.
- busy  out  1  high from the accepted start through the last write.
- done  out  1  one-cycle pulse after the final write.
- mem_raddr / mem_ren  out  8 / 1  coefficient read; rdata valid 1 cycle later.
- mem_rdata  in  32  signed coefficient.
- mem_waddr / mem_we / mem_wdata  out  8 / 1 / 32  coefficient write port.
- zeta_addr  out  8  twiddle ROM address; zeta_data valid 1 cycle later.
- zeta_data  in  32  zetas[k], in [0, Q).
- fpau_en  out  1  one-cycle operation strobe.
- fpau_op  out  4  4'b0000 = Cooley-Tukey (CT); 4'b0011 = Gentleman-Sande (GS).
- fpau_a0 / fpau_a1 / fpau_omega / fpau_acc  out  32 each  operands; fpau_acc is tied to 0.
- fpau_rsum / fpau_out2  in  32 each  centered FPAU results.

## Operation
- FSM states: DRAIN, IDLE, RD0, RD1, RD2, ISSUE, WAIT, WR0, WR1, DONE.
- Reset enters DRAIN. DRAIN holds for FPAU_LAT+1 cycles, because the FPAU has no reset and may finish an in-flight operation. It then moves to IDLE.
- Forward: len = 128, 64, …, 1. k runs 1..255 and increments once per block of len butterflies.
  - Butterfly pair (j, j+len) uses CT with omega = zetas[k].
  - a[j] ← rsum = a[j] + ω·a[j+len].
  - a[j+len] ← out2 = a[j] − ω·a[j+len].
- Inverse: len = 1, 2, …, 128. k runs 255 down to 1.
  - Uses GS with omega = −zetas[k] (two's-complement negation; the FPAU folds negatives).
  - a[j] ← rsum = a[j] + a[j+len].
  - a[j+len] ← out2 = (a[j] − a[j+len])·ω.
- Per butterfly:
  - RD0: raddr = j, zeta_addr = k.
  - RD1: raddr = j+len; capture a0 and zeta.
  - RD2: capture a1.
  - ISSUE: fpau_en = 1 with registered operands.
  - WAIT: FPAU_LAT cycles.
  - WR0: write rsum to j.
  - WR1: write out2 to j+len.
- Operands and fpau_op stay stable from ISSUE through WR1.
- After the last butterfly of the last layer: DONE pulses done, then the FSM returns to IDLE.
- start while busy is ignored. inv is latched at start, so changes mid-run have no effect.
- RST mid-run aborts immediately. Memory is left partially transformed; outputs take reset values.

## Timing
- Reset values: busy = 0, done = 0, all enables = 0, all address/data/operand outputs = 0, fpau_op = 0.
- Butterfly = 6 + FPAU_LAT cycles (9 at default).
- Transform = 1024 butterflies = 9216 cycles, plus 1 start cycle and 1 DONE cycle.
- fpau_en is never asserted twice within FPAU_LAT+1 cycles.
- Reads and writes never target the same address in the same cycle.

## Configuration
- SEQ_INVNTT_SCALE_EN defined:
  - Inverse runs append a 256-element pass: RD0, RD1, ISSUE, WAIT, WR0 = 4 + FPAU_LAT cycles each.
  - Each element uses CT with a0 = 0, a1 = a[i], omega = N_INV, and writes rsum to i.
  - Adds 1792 cycles at default.
- Undefined: inverse ends after layer 8, and outputs equal 256·x mod Q (centered).

## Test plan
- Reset, then start 2 cycles after RST deasserts → ignored (DRAIN); busy = 0, all outputs 0. Start after drain → busy = 1 next cycle.
- Forward, a[0] = 1, others 0 → all 256 coefficients = 1; done exactly 9217 cycles after start; 2048 mem_we pulses.
- Forward on all-zero → all zero; fpau_op = 0 on every en; zeta_addr sequence 1, 2, …, 255.
- Inverse with SEQ_INVNTT_SCALE_EN on all-ones → a[0] = 1, others 0. Without the macro → a[0] = 256, others 0.
- Random a[i] in [−4190208, 4190208], forward then inverse (macro on) → bit-exact originals.
- start pulsed and inv toggled mid-run, then RST mid-run → no restart or mode change; after RST, immediate idle outputs, and a new run after drain completes correctly.
